frame_stream_arbiter: RTL and testbench

//  Merges framed 64-bit streams from N_CH per-channel frame generators onto one output.

---
 rtl/frame_stream_arbiter_pkg.sv | 16 +
 rtl/frame_stream_arbiter_if.sv | 29 ++
 rtl/frame_stream_arbiter_rr_priority_picker.sv | 31 +++
 rtl/frame_stream_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_frame_stream_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_stream_arbiter_pkg.sv
// Shared constants and types for the framed-stream arbiter and the generators that feed it.
// Frame layout: header ID in the top byte, payload length in the low bits, footer ID in the low byte.
package frame_arb_pkg;
  localparam logic [7:0] HEADER_ID   = 8'hFF;
  localparam logic [7:0] FOOTER_ID   = 8'h0F;
  localparam int         ID_W        = 8;
  localparam int         HDR_LEN_LSB = 0;
  localparam int         FTR_ID_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HDR,
    PAYLOAD,
    TAIL
  } arb_state_t;
endpackage

// File: rtl/frame_stream_arbiter_if.sv
// Channel-side and downstream-side signals of the frame stream arbiter.
// Master drives channel requests/data and iREADY; slave is the arbiter.
interface frame_stream_arbiter_if #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 64
);
  localparam int GW = $clog2(N_CH);

  logic [N_CH-1:0]            CH_REQ;
  logic [N_CH-1:0]            CH_VALID;
  logic [N_CH*DATA_WIDTH-1:0] CH_DATA;
  logic [N_CH-1:0]            CH_READY;
  logic                       iREADY;
  logic                       oVALID;
  logic                       oLAST;
  logic [DATA_WIDTH-1:0]      DOUT;
  logic [GW-1:0]              GRANT_CH;
  logic                       FRAME_ERR;

  modport master (
    output CH_REQ, CH_VALID, CH_DATA, iREADY,
    input  CH_READY, oVALID, oLAST, DOUT, GRANT_CH, FRAME_ERR
  );

  modport slave (
    input  CH_REQ, CH_VALID, CH_DATA, iREADY,
    output CH_READY, oVALID, oLAST, DOUT, GRANT_CH, FRAME_ERR
  );
endinterface

// File: rtl/frame_stream_arbiter_rr_priority_picker.sv
// Combinational round-robin pick: first set bit of req at or after ptr, wrapping.
// Returns the winning index and whether any request was present.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] idx,
  output logic          found
);
  logic [GW:0]   pos;
  logic [GW-1:0] rot;

  // Scan from the far end back toward ptr so the nearest requester is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    rot   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (GW+1)'(i);
      if (pos >= (GW+1)'(N)) pos = pos - (GW+1)'(N);
      rot = pos[GW-1:0];
      if (req[rot]) begin
        idx   = rot;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/frame_stream_arbiter.sv
// Round-robin arbiter forwarding whole frames from N_CH channels onto one registered output,
// with header/footer/timeout/stray-word error detection. Define FRAME_ARB_STATS_EN for counters.
module frame_stream_arbiter
  import frame_arb_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int LEN_WIDTH     = 9,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic CLK,
  input  logic RESET,
  frame_stream_arbiter_if.slave bus
`ifdef FRAME_ARB_STATS_EN
  ,
  output logic [15:0] ERR_COUNT,
  output logic [31:0] FRAME_COUNT
`endif
);
  localparam int GW = $clog2(N_CH);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = ~(TIMEOUT_WIDTH'(1));

  arb_state_t            state_q, state_d;
  logic [GW-1:0]         ptr_q, ptr_d, gnt_q, gnt_d;
  logic [N_CH-1:0]       ready_q, ready_d;
  logic [LEN_WIDTH:0]    len_q, len_d, cnt_q, cnt_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic                  fwd_q, fwd_d;
  logic                  vld_q, vld_d, last_q, last_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic [GW-1:0]         pick_idx;
  logic                  pick_found;
  logic [DATA_WIDTH-1:0] word;
  logic                  gvld, stray, fault;

  rr_priority_picker #(.N(N_CH), .GW(GW)) u_pick (
    .req  (bus.CH_REQ),
    .ptr  (ptr_q),
    .idx  (pick_idx),
    .found(pick_found)
  );

  // ready_q is one-hot on the granted channel while a frame is open, zero in IDLE,
  // so any valid outside it is a stray word.
  assign word  = bus.CH_DATA[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
  assign gvld  = |(bus.CH_VALID & ready_q);
  assign stray = |(bus.CH_VALID & ~ready_q);

  function automatic logic [GW-1:0] next_ch(input logic [GW-1:0] ch);
    return (ch == GW'(N_CH - 1)) ? '0 : ch + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ready_d = ready_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    fwd_d   = fwd_q;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    dout_d  = dout_q;
    fault   = stray;
    case (state_q)
      IDLE: begin
        if (bus.iREADY && pick_found) begin
          gnt_d   = pick_idx;
          ready_d = '0;
          ready_d[pick_idx] = 1'b1;
          len_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          fwd_d   = 1'b0;
          state_d = WAIT_HDR;
        end
      end
      default: begin
        if (gvld) begin
          tmo_d = '0;
          if (state_q == WAIT_HDR) begin
            if (word[DATA_WIDTH-1 -: ID_W] == HEADER_ID) begin
              vld_d   = 1'b1;
              dout_d  = word;
              fwd_d   = 1'b1;
              len_d   = {1'b0, word[HDR_LEN_LSB +: LEN_WIDTH]};
              state_d = (word[HDR_LEN_LSB +: LEN_WIDTH] == '0) ? TAIL : PAYLOAD;
            end else begin
              fault = 1'b1;
            end
          end else if (state_q == PAYLOAD) begin
            vld_d  = 1'b1;
            dout_d = word;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == len_q) state_d = TAIL;
          end else begin
            vld_d   = 1'b1;
            last_d  = 1'b1;
            dout_d  = word;
            if (word[FTR_ID_LSB +: ID_W] != FOOTER_ID) fault = 1'b1;
            ready_d = '0;
            ptr_d   = next_ch(gnt_q);
            state_d = IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Abort marker only when the downstream already saw part of this frame.
          fault   = 1'b1;
          last_d  = fwd_q;
          ready_d = '0;
          ptr_d   = next_ch(gnt_q);
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    endcase
    err_d = fault;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ready_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      fwd_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      dout_q  <= '1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ready_q <= ready_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      fwd_q   <= fwd_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  assign bus.CH_READY  = ready_q;
  assign bus.oVALID    = vld_q;
  assign bus.oLAST     = last_q;
  assign bus.DOUT      = dout_q;
  assign bus.GRANT_CH  = gnt_q;
  assign bus.FRAME_ERR = err_q;

`ifdef FRAME_ARB_STATS_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [31:0] frm_cnt_q, frm_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    frm_cnt_d = frm_cnt_q;
    if (err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 1'b1;
    if ((state_q == TAIL) && gvld) frm_cnt_d = frm_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_cnt_q <= '0;
      frm_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      frm_cnt_q <= frm_cnt_d;
    end
  end

  assign ERR_COUNT   = err_cnt_q;
  assign FRAME_COUNT = frm_cnt_q;
`endif
endmodule

// File: tb/tb_frame_stream_arbiter.sv
// Directed self-checking bench for frame_stream_arbiter (N_CH=4, 64-bit words).
// Inputs change on the falling edge; a monitor captures outputs 1 time unit after the rising edge.
module tb_frame_stream_arbiter;
  localparam int N_CH = 4;
  localparam int DW   = 64;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  frame_stream_arbiter_if #(.N_CH(N_CH), .DATA_WIDTH(DW)) bus ();

`ifdef FRAME_ARB_STATS_EN
  logic [15:0] err_count;
  logic [31:0] frame_count;
`endif

  frame_stream_arbiter #(.N_CH(N_CH), .DATA_WIDTH(DW), .LEN_WIDTH(9), .TIMEOUT_WIDTH(8)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
`ifdef FRAME_ARB_STATS_EN
    ,
    .ERR_COUNT  (err_count),
    .FRAME_COUNT(frame_count)
`endif
  );

  logic [DW-1:0] oq_data[$];
  logic          oq_last[$];
  logic [1:0]    oq_gnt[$];
  int            n_err   = 0;
  int            n_abort = 0;

  always begin
    @(posedge clk);
    #1;
    if (bus.oVALID === 1'b1) begin
      oq_data.push_back(bus.DOUT);
      oq_last.push_back(bus.oLAST);
      oq_gnt.push_back(bus.GRANT_CH);
    end
    if (bus.FRAME_ERR === 1'b1) n_err++;
    if (bus.oVALID === 1'b0 && bus.oLAST === 1'b1) n_abort++;
  end

  function automatic logic [DW-1:0] hdr_w(input int len);
    return {8'hFF, 47'd0, 9'(len)};
  endfunction
  function automatic logic [DW-1:0] pay_w(input int ch, input int i);
    return {8'hD0, 24'(ch), 32'(i)};
  endfunction
  function automatic logic [DW-1:0] ftr_w(input int ch);
    return {8'hE0, 48'(ch), 8'h0F};
  endfunction

  task automatic put(input int ch, input logic [DW-1:0] w);
    bus.CH_VALID = '0;
    bus.CH_DATA  = '0;
    bus.CH_VALID[ch] = 1'b1;
    bus.CH_DATA[ch*DW +: DW] = w;
    @(negedge clk);
    bus.CH_VALID = '0;
  endtask

  task automatic send_frame(input int ch, input int len);
    put(ch, hdr_w(len));
    for (int i = 0; i < len; i++) put(ch, pay_w(ch, i));
    put(ch, ftr_w(ch));
  endtask

  task automatic wait_ready(output int ch, output bit ok);
    ok = 1'b0;
    ch = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.CH_READY != '0) begin
        ok = 1'b1;
        for (int j = 0; j < N_CH; j++) if (bus.CH_READY[j]) ch = j;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.CH_REQ   = '0;
    bus.CH_VALID = '0;
    bus.CH_DATA  = '0;
    bus.iREADY   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.CH_REQ   = '0;
    bus.CH_VALID = '0;
    bus.CH_DATA  = '0;
    bus.iREADY   = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.CH_READY !== 4'b0000 || bus.oVALID !== 1'b0 || bus.oLAST !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b last=%b want 0000/0/0", bus.CH_READY, bus.oVALID, bus.oLAST);
    end
    total++;
    if (bus.DOUT !== {DW{1'b1}} || bus.GRANT_CH !== 2'd0 || bus.FRAME_ERR !== 1'b0) begin
      bad++;
      $display("FAIL reset_data: got dout=%h gnt=%0d err=%b want all-ones/0/0", bus.DOUT, bus.GRANT_CH, bus.FRAME_ERR);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] w[6];
    int qb, eb;
    w[0] = hdr_w(4);
    for (int i = 0; i < 4; i++) w[i+1] = pay_w(0, i);
    w[5] = ftr_w(0);
    qb = oq_data.size();
    eb = n_err;
    bus.iREADY = 1'b1;
    bus.CH_REQ = 4'b0001;
    @(negedge clk);
    total++;
    if (bus.CH_READY !== 4'b0001) begin
      bad++;
      $display("FAIL t1_grant: got %b want 0001", bus.CH_READY);
    end
    for (int i = 0; i < 6; i++) begin
      put(0, w[i]);
      if (i == 5) bus.CH_REQ = '0;
      total++;
      if (bus.oVALID !== 1'b1 || bus.DOUT !== w[i] || bus.oLAST !== (i == 5)) begin
        bad++;
        $display("FAIL t1_word%0d: got vld=%b last=%b dout=%h want 1/%0d/%h", i, bus.oVALID, bus.oLAST, bus.DOUT, (i == 5), w[i]);
      end
    end
    total++;
    if (bus.CH_READY !== 4'b0000 || oq_data.size() - qb !== 6 || n_err - eb !== 0) begin
      bad++;
      $display("FAIL t1_end: got rdy=%b words=%0d errs=%0d want 0000/6/0", bus.CH_READY, oq_data.size() - qb, n_err - eb);
    end
  endtask

  task automatic test_round_robin();
    int exp_ch[5] = '{0, 1, 2, 3, 0};
    int ch, qb, eb;
    bit ok;
    logic [DW-1:0] ew;
    do_reset();
    qb = oq_data.size();
    eb = n_err;
    bus.CH_REQ = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_ready(ch, ok);
      total++;
      if (!ok || ch != exp_ch[f] || bus.GRANT_CH !== 2'(exp_ch[f])) begin
        bad++;
        $display("FAIL t2_grant%0d: got ok=%0d ch=%0d gnt=%0d want ch %0d", f, ok, ch, bus.GRANT_CH, exp_ch[f]);
        return;
      end
      send_frame(ch, 2);
      if (f == 4) bus.CH_REQ = '0;
    end
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 4; i++) begin
        ew = (i == 0) ? hdr_w(2) : (i == 3) ? ftr_w(exp_ch[f]) : pay_w(exp_ch[f], i - 1);
        total++;
        if (oq_data.size() <= qb + 4*f + i) begin
          bad++;
          $display("FAIL t2_missing: got %0d words want 20", oq_data.size() - qb);
        end else if (oq_data[qb+4*f+i] !== ew || oq_last[qb+4*f+i] !== (i == 3) || oq_gnt[qb+4*f+i] !== 2'(exp_ch[f])) begin
          bad++;
          $display("FAIL t2_word%0d_%0d: got %h last=%b gnt=%0d want %h last=%0d gnt=%0d", f, i,
                   oq_data[qb+4*f+i], oq_last[qb+4*f+i], oq_gnt[qb+4*f+i], ew, (i == 3), exp_ch[f]);
        end
      end
    end
    total++;
    if (n_err - eb !== 0) begin
      bad++;
      $display("FAIL t2_err: got %0d pulses want 0", n_err - eb);
    end
  endtask

  task automatic test_iready_gate();
    int qb;
    qb = oq_data.size();
    bus.iREADY = 1'b0;
    bus.CH_REQ = 4'b0010;
    repeat (3) @(negedge clk);
    total++;
    if (bus.CH_READY !== 4'b0000) begin
      bad++;
      $display("FAIL t3_held: got %b want 0000", bus.CH_READY);
    end
    bus.iREADY = 1'b1;
    @(negedge clk);
    total++;
    if (bus.CH_READY !== 4'b0010) begin
      bad++;
      $display("FAIL t3_grant: got %b want 0010", bus.CH_READY);
    end
    send_frame(1, 0);
    bus.CH_REQ = '0;
    total++;
    if (oq_data.size() - qb !== 2 || oq_data[qb] !== hdr_w(0) || oq_data[qb+1] !== ftr_w(1) || oq_last[qb+1] !== 1'b1) begin
      bad++;
      $display("FAIL t3_len0: got %0d words want hdr+footer", oq_data.size() - qb);
    end
  endtask

  task automatic test_stray();
    put(1, pay_w(1, 9));
    total++;
    if (bus.FRAME_ERR !== 1'b1 || bus.oVALID !== 1'b0) begin
      bad++;
      $display("FAIL stray_idle: got err=%b vld=%b want 1/0", bus.FRAME_ERR, bus.oVALID);
    end
    bus.CH_REQ = 4'b0001;
    @(negedge clk);
    bus.CH_VALID = 4'b1001;
    bus.CH_DATA  = '0;
    bus.CH_DATA[0 +: DW]    = hdr_w(0);
    bus.CH_DATA[3*DW +: DW] = pay_w(3, 7);
    @(negedge clk);
    bus.CH_VALID = '0;
    total++;
    if (bus.FRAME_ERR !== 1'b1 || bus.oVALID !== 1'b1 || bus.DOUT !== hdr_w(0)) begin
      bad++;
      $display("FAIL stray_busy: got err=%b vld=%b dout=%h want 1/1/%h", bus.FRAME_ERR, bus.oVALID, bus.DOUT, hdr_w(0));
    end
    put(0, ftr_w(0));
    bus.CH_REQ = '0;
    total++;
    if (bus.FRAME_ERR !== 1'b0 || bus.oLAST !== 1'b1 || bus.DOUT !== ftr_w(0)) begin
      bad++;
      $display("FAIL stray_footer: got err=%b last=%b dout=%h want 0/1/%h", bus.FRAME_ERR, bus.oLAST, bus.DOUT, ftr_w(0));
    end
  endtask

  task automatic test_bad_header();
    int ch, qb;
    bit ok;
    logic [DW-1:0] badh;
    badh = {8'hAA, 47'd0, 9'd1};
    bus.CH_REQ = 4'b0100;
    wait_ready(ch, ok);
    qb = oq_data.size();
    put(2, badh);
    total++;
    if (!ok || bus.FRAME_ERR !== 1'b1 || bus.oVALID !== 1'b0) begin
      bad++;
      $display("FAIL t4_badhdr: got ok=%0d err=%b vld=%b want 1/1/0", ok, bus.FRAME_ERR, bus.oVALID);
    end
    @(negedge clk);
    total++;
    if (bus.FRAME_ERR !== 1'b0 || bus.CH_READY !== 4'b0100) begin
      bad++;
      $display("FAIL t4_hold: got err=%b rdy=%b want 0/0100", bus.FRAME_ERR, bus.CH_READY);
    end
    send_frame(2, 1);
    bus.CH_REQ = '0;
    total++;
    if (oq_data.size() - qb !== 3 || oq_data[qb] !== hdr_w(1) || oq_data[qb+1] !== pay_w(2, 0) || oq_data[qb+2] !== ftr_w(2)) begin
      bad++;
      $display("FAIL t4_frame: got %0d words first=%h want 3 first=%h", oq_data.size() - qb, oq_data[qb], hdr_w(1));
    end
  endtask

  task automatic test_timeout();
    int ch, seen, ab;
    bit ok;
    bus.CH_REQ = 4'b0110;
    wait_ready(ch, ok);
    total++;
    if (!ok || ch != 1) begin
      bad++;
      $display("FAIL t5_grant: got ch=%0d want 1", ch);
    end
    ab = n_abort;
    put(1, hdr_w(4));
    put(1, pay_w(1, 0));
    put(1, pay_w(1, 1));
    seen = -1;
    for (int k = 1; k <= 300 && seen < 0; k++) begin
      @(negedge clk);
      if (bus.FRAME_ERR === 1'b1) seen = k;
    end
    total++;
    if (seen != 255) begin
      bad++;
      $display("FAIL t5_latency: got err after %0d idle cycles want 255", seen);
    end
    total++;
    if (bus.oVALID !== 1'b0 || bus.oLAST !== 1'b1 || bus.CH_READY !== 4'b0000) begin
      bad++;
      $display("FAIL t5_abort: got vld=%b last=%b rdy=%b want 0/1/0000", bus.oVALID, bus.oLAST, bus.CH_READY);
    end
    @(negedge clk);
    total++;
    if (bus.CH_READY !== 4'b0100 || bus.GRANT_CH !== 2'd2 || n_abort - ab !== 1) begin
      bad++;
      $display("FAIL t5_next: got rdy=%b gnt=%0d aborts=%0d want 0100/2/1", bus.CH_READY, bus.GRANT_CH, n_abort - ab);
    end
    send_frame(2, 0);
    bus.CH_REQ = '0;
  endtask

  task automatic test_reset_mid_frame();
    int ch;
    bit ok;
    bus.CH_REQ = 4'b1000;
    wait_ready(ch, ok);
    put(3, hdr_w(4));
    put(3, pay_w(3, 0));
    rst = 1'b1;
    bus.CH_REQ = 4'b1010;
    @(negedge clk);
    total++;
    if (bus.CH_READY !== 4'b0000 || bus.oVALID !== 1'b0 || bus.oLAST !== 1'b0 ||
        bus.DOUT !== {DW{1'b1}} || bus.GRANT_CH !== 2'd0 || bus.FRAME_ERR !== 1'b0) begin
      bad++;
      $display("FAIL t6_reset: got rdy=%b vld=%b last=%b dout=%h gnt=%0d err=%b want reset values",
               bus.CH_READY, bus.oVALID, bus.oLAST, bus.DOUT, bus.GRANT_CH, bus.FRAME_ERR);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.CH_READY !== 4'b0010 || bus.GRANT_CH !== 2'd1) begin
      bad++;
      $display("FAIL t6_regrant: got rdy=%b gnt=%0d want 0010/1", bus.CH_READY, bus.GRANT_CH);
    end
    send_frame(1, 0);
    bus.CH_REQ = '0;
  endtask

  initial begin
    rst = 1'b1;
    bus.CH_REQ   = '0;
    bus.CH_VALID = '0;
    bus.CH_DATA  = '0;
    bus.iREADY   = 1'b0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_iready_gate();
    test_stray();
    test_bad_header();
    test_timeout();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
